lector_rtc: RTL

LECTOR_RTC -- requirements
Module: lector_rtc

---
 rtl/lector_rtc_pkg.sv | 48 ++++
 rtl/lector_rtc_temporizador.sv | 62 ++++++
 rtl/lector_rtc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lector_rtc_pkg.sv
// Shared constants, state encoding and payload types for the RTC read/write blocks.
package lector_rtc_pkg;

  localparam int unsigned T_CICLO_DEF   = 43;
  localparam int unsigned T_MUESTRA_DEF = 34;

  localparam int unsigned CS_INI = 2;
  localparam int unsigned CS_FIN = 40;
  localparam int unsigned AD_INI = 2;
  localparam int unsigned AD_FIN = 12;
  localparam int unsigned WR_INI = 4;
  localparam int unsigned WR_FIN = 10;
  localparam int unsigned RD_INI = 24;
  localparam int unsigned RD_FIN = 36;

  localparam int unsigned N_REG    = 6;
  localparam int unsigned W_INDICE = 3;
  localparam int unsigned W_DATO   = 8;

  localparam logic [W_DATO-1:0] DIR_SEG_DEF  = 8'h21;
  localparam logic [W_DATO-1:0] DIR_MIN_DEF  = 8'h22;
  localparam logic [W_DATO-1:0] DIR_HOR_DEF  = 8'h23;
  localparam logic [W_DATO-1:0] DIR_DIA_DEF  = 8'h24;
  localparam logic [W_DATO-1:0] DIR_MES_DEF  = 8'h25;
  localparam logic [W_DATO-1:0] DIR_ANIO_DEF = 8'h26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEER  = 2'd1,
    ST_LISTO = 2'd2
  } estado_t;

  // Seconds occupy the low byte so the struct lines up with a shadow array indexed 0..5.
  typedef struct packed {
    logic [W_DATO-1:0] anio;
    logic [W_DATO-1:0] mes;
    logic [W_DATO-1:0] dia;
    logic [W_DATO-1:0] horas;
    logic [W_DATO-1:0] minutos;
    logic [W_DATO-1:0] segundos;
  } fecha_t;

  function automatic logic en_ventana(input int unsigned c, input int unsigned lo,
                                      input int unsigned hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/lector_rtc_temporizador.sv
// Per-transaction clock counter with registered strobe and bus-enable decode.
module temporizador_rtc
  import lector_rtc_pkg::*;
#(
  parameter int unsigned T_CICLO   = T_CICLO_DEF,
  parameter int unsigned T_MUESTRA = T_MUESTRA_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_activo,
  output logic o_fin_c,
  output logic o_muestra_c,
  output logic o_carga_dir_c,
  output logic o_cs_n,
  output logic o_ad_n,
  output logic o_wr_n,
  output logic o_rd_n,
  output logic o_bus_oe
);

  localparam int unsigned W_CUENTA = $clog2(T_CICLO);

  logic [W_CUENTA-1:0] r_cuenta;
  logic [W_CUENTA-1:0] w_cuenta_sig;
  logic                r_cs_n, r_ad_n, r_wr_n, r_rd_n, r_bus_oe;

  always_comb begin
    w_cuenta_sig = '0;
    if (i_activo && (r_cuenta != W_CUENTA'(T_CICLO - 1)))
      w_cuenta_sig = r_cuenta + W_CUENTA'(1);
  end

  assign o_fin_c       = i_activo && (r_cuenta == W_CUENTA'(T_CICLO - 1));
  assign o_muestra_c   = i_activo && (r_cuenta == W_CUENTA'(T_MUESTRA));
  assign o_carga_dir_c = en_ventana(32'(w_cuenta_sig), AD_INI, AD_FIN);

  // Strobes decode the upcoming count so the registered value lines up with the count itself.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cuenta <= '0;
      r_cs_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_bus_oe <= 1'b0;
    end else begin
      r_cuenta <= w_cuenta_sig;
      r_cs_n   <= !en_ventana(32'(w_cuenta_sig), CS_INI, CS_FIN);
      r_ad_n   <= !en_ventana(32'(w_cuenta_sig), AD_INI, AD_FIN);
      r_wr_n   <= !en_ventana(32'(w_cuenta_sig), WR_INI, WR_FIN);
      r_rd_n   <= !en_ventana(32'(w_cuenta_sig), RD_INI, RD_FIN);
      r_bus_oe <= o_carga_dir_c;
    end
  end

  assign o_cs_n   = r_cs_n;
  assign o_ad_n   = r_ad_n;
  assign o_wr_n   = r_wr_n;
  assign o_rd_n   = r_rd_n;
  assign o_bus_oe = r_bus_oe;

endmodule

// File: rtl/lector_rtc.sv
// Reads the six RTC time/date registers in sequence and publishes them atomically.
module lector_rtc
  import lector_rtc_pkg::*;
#(
  parameter int unsigned       T_CICLO   = T_CICLO_DEF,
  parameter int unsigned       T_MUESTRA = T_MUESTRA_DEF,
  parameter logic [W_DATO-1:0] DIR_SEG   = DIR_SEG_DEF,
  parameter logic [W_DATO-1:0] DIR_MIN   = DIR_MIN_DEF,
  parameter logic [W_DATO-1:0] DIR_HOR   = DIR_HOR_DEF,
  parameter logic [W_DATO-1:0] DIR_DIA   = DIR_DIA_DEF,
  parameter logic [W_DATO-1:0] DIR_MES   = DIR_MES_DEF,
  parameter logic [W_DATO-1:0] DIR_ANIO  = DIR_ANIO_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_lectura,
  input  logic              reset_listo_lectura,
  input  logic [W_DATO-1:0] bus_in_rtc,
  output logic [W_DATO-1:0] bus_out_lectura,
  output logic              bus_oe,
  output logic              cs_n,
  output logic              ad_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic [W_DATO-1:0] segundos,
  output logic [W_DATO-1:0] minutos,
  output logic [W_DATO-1:0] horas,
  output logic [W_DATO-1:0] dia,
  output logic [W_DATO-1:0] mes,
  output logic [W_DATO-1:0] anio,
  output logic              listo_lectura,
  output logic              ocupado
);

  estado_t                       r_estado, w_estado_sig;
  logic                          r_listo, r_ocupado, w_listo_sig, w_ocupado_sig;
  logic [W_INDICE-1:0]           r_indice;
  logic [N_REG-1:0][W_DATO-1:0]  r_sombra;
  fecha_t                        r_fecha;
  logic [W_DATO-1:0]             r_bus_out, w_dir;
  logic                          w_fin_c, w_muestra_c, w_carga_dir_c, w_ultima;

  temporizador_rtc #(
    .T_CICLO   (T_CICLO),
    .T_MUESTRA (T_MUESTRA)
  ) u_temporizador (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_activo      (r_estado == ST_LEER),
    .o_fin_c       (w_fin_c),
    .o_muestra_c   (w_muestra_c),
    .o_carga_dir_c (w_carga_dir_c),
    .o_cs_n        (cs_n),
    .o_ad_n        (ad_n),
    .o_wr_n        (wr_n),
    .o_rd_n        (rd_n),
    .o_bus_oe      (bus_oe)
  );

  assign w_ultima = w_fin_c && (r_indice == W_INDICE'(N_REG - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado  <= ST_IDLE;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_estado  <= w_estado_sig;
      r_listo   <= w_listo_sig;
      r_ocupado <= w_ocupado_sig;
    end
  end

  // Acknowledge in LISTO always returns to IDLE; a new start is only considered from IDLE.
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      ST_IDLE:  if (enable_lectura && !r_listo) w_estado_sig = ST_LEER;
      ST_LEER:  if (w_ultima)                   w_estado_sig = ST_LISTO;
      ST_LISTO: if (reset_listo_lectura)        w_estado_sig = ST_IDLE;
      default:                                  w_estado_sig = ST_IDLE;
    endcase
  end

  always_comb begin
    w_listo_sig   = (w_estado_sig == ST_LISTO);
    w_ocupado_sig = (w_estado_sig == ST_LEER);
  end

  always_comb begin
    w_dir = '0;
    case (r_indice)
      W_INDICE'(0): w_dir = DIR_SEG;
      W_INDICE'(1): w_dir = DIR_MIN;
      W_INDICE'(2): w_dir = DIR_HOR;
      W_INDICE'(3): w_dir = DIR_DIA;
      W_INDICE'(4): w_dir = DIR_MES;
      default:      w_dir = DIR_ANIO;
    endcase
  end

  // Shadows collect one sequence; the visible outputs copy them only when the last transaction ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_indice  <= '0;
      r_sombra  <= '0;
      r_fecha   <= '0;
      r_bus_out <= '0;
    end else begin
      if (r_estado == ST_IDLE)
        r_indice <= '0;
      else if (w_fin_c)
        r_indice <= w_ultima ? '0 : r_indice + W_INDICE'(1);
      if (w_muestra_c) begin
        for (int unsigned i = 0; i < N_REG; i++)
          if (r_indice == W_INDICE'(i)) r_sombra[i] <= bus_in_rtc;
      end
      if (w_carga_dir_c)
        r_bus_out <= w_dir;
      if (w_ultima)
        r_fecha <= fecha_t'(r_sombra);
    end
  end

  assign bus_out_lectura = r_bus_out;
  assign listo_lectura   = r_listo;
  assign ocupado         = r_ocupado;
  assign segundos        = r_fecha.segundos;
  assign minutos         = r_fecha.minutos;
  assign horas           = r_fecha.horas;
  assign dia             = r_fecha.dia;
  assign mes             = r_fecha.mes;
  assign anio            = r_fecha.anio;

endmodule
